div_result_capture: RTL and testbench

//  Downstream stage of the iterative subtract-count divider. Tracks one division job from its

---
 rtl/div_result_capture.sv | 199 +++++++++++++++++++
 tb/tb_div_result_capture.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_result_capture.sv
// Result capture stage for the iterative subtract-count divider: job FSM, quotient fix-up, result FIFO.
// Optional statistics counters (job_cnt/err_cnt) are enabled by defining DIV_CAPTURE_STATS_EN.
module div_result_capture #(
    parameter int W          = 5,
    parameter int DEPTH      = 4,
    parameter int QUO_OFFSET = 1,
    parameter int TIMEOUT    = 40
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] dvs_in,
    input  logic [W-1:0] quo_in,
    input  logic [W-1:0] rem_in,
    output logic         busy,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W-1:0] res_quo,
    output logic [W-1:0] res_rem,
    output logic         res_err,
    output logic         ovf
`ifdef DIV_CAPTURE_STATS_EN
    ,
    output logic [15:0]  job_cnt,
    output logic [15:0]  err_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_CAPT
    } state_t;

    typedef struct packed {
        logic [W-1:0] quo;
        logic [W-1:0] rem;
        logic         err;
    } entry_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   tcnt_q, tcnt_d;
    entry_t          lat_q, lat_d;
    logic            push_req;

    entry_t          mem_q [DEPTH];
    logic [AW-1:0]   rd_q, rd_d;
    logic [AW-1:0]   wr_q, wr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    entry_t          head_q, head_d;
    logic            ovf_q, ovf_d;

    logic            full;
    logic            pop;
    logic            push;

    // Job FSM: start always wins, abandoning any in-flight job without a push
    always_comb begin
        state_d  = state_q;
        tcnt_d   = tcnt_q;
        lat_d    = lat_q;
        push_req = 1'b0;
        case (state_q)
            S_IDLE: begin
                tcnt_d = '0;
                if (start) state_d = S_LOAD;
            end
            S_LOAD: begin
                tcnt_d = '0;
                if (start) begin
                    state_d = S_LOAD;
                end else if (dvs_in == '0) begin
                    lat_d.quo = '0;
                    lat_d.rem = '0;
                    lat_d.err = 1'b1;
                    state_d   = S_CAPT;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (start) begin
                    state_d = S_LOAD;
                end else if (!(rem_in > dvs_in)) begin
                    lat_d.quo = quo_in - W'(QUO_OFFSET);
                    lat_d.rem = rem_in;
                    lat_d.err = 1'b0;
                    state_d   = S_CAPT;
                end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
                    lat_d.quo = quo_in - W'(QUO_OFFSET);
                    lat_d.rem = rem_in;
                    lat_d.err = 1'b1;
                    state_d   = S_CAPT;
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end
            S_CAPT: begin
                tcnt_d = '0;
                if (start) begin
                    state_d = S_LOAD;
                end else begin
                    push_req = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            tcnt_q  <= '0;
            lat_q   <= '0;
        end else begin
            state_q <= state_d;
            tcnt_q  <= tcnt_d;
            lat_q   <= lat_d;
        end
    end

    assign full = (cnt_q == CW'(DEPTH));
    assign pop  = (cnt_q != '0) && res_ready;
    assign push = push_req && (!full || pop);

    // Head register is preloaded with whatever entry will be at the front after this cycle
    always_comb begin
        rd_d  = rd_q + AW'(pop);
        wr_d  = wr_q + AW'(push);
        cnt_d = cnt_q + CW'(push) - CW'(pop);
        ovf_d = ovf_q || (push_req && full && !pop);
        if (cnt_d == '0) begin
            head_d = '0;
        end else if ((cnt_q - CW'(pop)) == '0) begin
            head_d = lat_q;
        end else begin
            head_d = mem_q[rd_d];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_q   <= '0;
            wr_q   <= '0;
            cnt_q  <= '0;
            head_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (push) mem_q[wr_q] <= lat_q;
            rd_q   <= rd_d;
            wr_q   <= wr_d;
            cnt_q  <= cnt_d;
            head_q <= head_d;
            ovf_q  <= ovf_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign res_valid = (cnt_q != '0);
    assign res_quo   = head_q.quo;
    assign res_rem   = head_q.rem;
    assign res_err   = head_q.err;
    assign ovf       = ovf_q;

`ifdef DIV_CAPTURE_STATS_EN
    logic [15:0] job_cnt_q, job_cnt_d;
    logic [15:0] err_cnt_q, err_cnt_d;

    always_comb begin
        job_cnt_d = job_cnt_q;
        err_cnt_d = err_cnt_q;
        if (push && (job_cnt_q != '1)) job_cnt_d = job_cnt_q + 16'd1;
        if (push && lat_q.err && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            job_cnt_q <= '0;
            err_cnt_q <= '0;
        end else begin
            job_cnt_q <= job_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign job_cnt = job_cnt_q;
    assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_div_result_capture.sv
// Self-checking bench for div_result_capture with an emulated subtract-count divider.
// Define DIV_CAPTURE_STATS_EN to also check the job/error statistics counters.
module tb_div_result_capture;

    localparam int W       = 5;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 40;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] dvs_in = '0;
    logic [W-1:0] quo_in = '0;
    logic [W-1:0] rem_in = '0;
    logic         busy, res_valid, res_err, ovf;
    logic         res_ready = 1'b0;
    logic [W-1:0] res_quo, res_rem;
`ifdef DIV_CAPTURE_STATS_EN
    logic [15:0]  job_cnt, err_cnt;
`endif

    div_result_capture #(.W(W), .DEPTH(DEPTH), .QUO_OFFSET(1), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .start(start), .dvs_in(dvs_in), .quo_in(quo_in), .rem_in(rem_in),
        .busy(busy), .res_valid(res_valid), .res_ready(res_ready), .res_quo(res_quo),
        .res_rem(res_rem), .res_err(res_err), .ovf(ovf)
`ifdef DIV_CAPTURE_STATS_EN
        , .job_cnt(job_cnt), .err_cnt(err_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Divider emulation: start reloads remainder and restarts counter at 1
    logic [W-1:0] dvd = '0;
    logic         hold = 1'b0;
    always @(posedge clk) begin
        if (start) begin
            rem_in <= dvd;
            quo_in <= W'(1);
        end else if (!hold && rem_in > dvs_in) begin
            rem_in <= rem_in - dvs_in;
            quo_in <= quo_in + W'(1);
        end
    end

    typedef struct {int quo; int rem; int err;} exp_t;
    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   exp_jobs = 0;
    int   exp_errs = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Divider stops once remainder <= divisor; k = number of subtractions performed
    function automatic void model_div(input int a, input int d, output int q, output int r, output int n);
        int k;
        if (a <= d) k = 0;
        else        k = (a + d - 1) / d - 1;
        q = k;
        r = a - k * d;
        n = (k == 0) ? 1 : k;
    endfunction

    function automatic void exp_push(input int q, input int r, input int e);
        exp_t x;
        x.quo = q; x.rem = r; x.err = e;
        if (exp_q.size() < DEPTH) begin
            exp_q.push_back(x);
            exp_jobs++;
            if (e != 0) exp_errs++;
        end
    endfunction

    task automatic do_start(input int a, input int d);
        dvd    = W'(a);
        dvs_in = W'(d);
        start  = 1'b1;
        tick();
        start  = 1'b0;
    endtask

    task automatic wait_idle(output int lat);
        lat = 1;
        while (busy && lat < 200) begin
            tick();
            lat++;
        end
        check("wait_busy_bound", busy, 0);
    endtask

    task automatic check_head(input string tag);
        exp_t x;
        x = (exp_q.size() != 0) ? exp_q[0] : '{-1, -1, -1};
        check({tag, "_valid"}, res_valid, 1);
        check({tag, "_quo"}, res_quo, x.quo);
        check({tag, "_rem"}, res_rem, x.rem);
        check({tag, "_err"}, res_err, x.err);
    endtask

    task automatic pop_check(input string tag);
        check_head(tag);
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    initial begin
        int lat, a, d, q, r, n;

        #12;
        check("rst_busy", busy, 0);
        check("rst_valid", res_valid, 0);
        check("rst_quo", res_quo, 0);
        check("rst_rem", res_rem, 0);
        check("rst_err", res_err, 0);
        check("rst_ovf", ovf, 0);
        rst = 1'b0;
        tick();

        // Basic job 17/3
        do_start(17, 3);
        wait_idle(lat);
        check("t1_latency", lat, 8);
        check("t1_quo_const", res_quo, 5);
        check("t1_rem_const", res_rem, 2);
        model_div(17, 3, q, r, n);
        exp_push(q, r, 0);
        pop_check("t1");
        check("t1_empty", res_valid, 0);

        // Divide by zero
        do_start(13, 0);
        wait_idle(lat);
        check("t2_latency", lat, 3);
        exp_push(0, 0, 1);
        pop_check("t2");

        // Timeout: remainder frozen above divisor
        hold = 1'b1;
        do_start(9, 2);
        wait_idle(lat);
        hold = 1'b0;
        check("t3_latency", lat, 3 + TIMEOUT);
        check("t3_valid", res_valid, 1);
        check("t3_err", res_err, 1);
        exp_jobs++;
        exp_errs++;
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("t3_empty", res_valid, 0);

        // Random jobs against the arithmetic model
        for (int i = 0; i < 12; i++) begin
            a = int'($urandom_range(0, 31));
            d = int'($urandom_range(1, 31));
            model_div(a, d, q, r, n);
            do_start(a, d);
            wait_idle(lat);
            check("rnd_latency", lat, 3 + n);
            exp_push(q, r, 0);
            pop_check("rnd");
        end

        // Fill FIFO with consumer stalled
        for (int i = 0; i < DEPTH; i++) begin
            a = int'($urandom_range(0, 31));
            d = int'($urandom_range(1, 31));
            model_div(a, d, q, r, n);
            do_start(a, d);
            wait_idle(lat);
            exp_push(q, r, 0);
        end
        tick(); tick();
        check_head("full_hold");
        check("full_ovf", ovf, 0);

        // Pop coincident with capture while full: push must succeed
        do_start(7, 0);
        tick();
        check_head("capt_pop");
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        void'(exp_q.pop_front());
        exp_push(0, 0, 1);
        check("capt_pop_ovf", ovf, 0);
        check("capt_pop_busy", busy, 0);

        // Push into full FIFO is dropped
        do_start(20, 6);
        wait_idle(lat);
        check("drop_ovf", ovf, 1);
        for (int i = 0; i < DEPTH; i++) pop_check("drain");
        check("drain_empty", res_valid, 0);
        check("drain_ovf_sticky", ovf, 1);

        // Restart in the very cycle the first job finishes
        do_start(17, 3);
        for (int i = 0; i < 5; i++) tick();
        do_start(20, 6);
        wait_idle(lat);
        model_div(20, 6, q, r, n);
        check("t5_latency", lat, 3 + n);
        exp_push(q, r, 0);
        pop_check("t5");
        check("t5_single", res_valid, 0);

        // Asynchronous reset mid-RUN with two queued entries
        for (int i = 0; i < 2; i++) begin
            do_start(25, 4);
            wait_idle(lat);
            model_div(25, 4, q, r, n);
            exp_push(q, r, 0);
        end
        do_start(31, 1);
        tick(); tick(); tick();
`ifdef DIV_CAPTURE_STATS_EN
        check("stats_jobs", job_cnt, exp_jobs);
        check("stats_errs", err_cnt, exp_errs);
`endif
        #2;
        rst = 1'b1;
        #1;
        check("t6_busy", busy, 0);
        check("t6_valid", res_valid, 0);
        check("t6_quo", res_quo, 0);
        check("t6_rem", res_rem, 0);
        check("t6_err", res_err, 0);
        check("t6_ovf", ovf, 0);
`ifdef DIV_CAPTURE_STATS_EN
        check("t6_jobs", job_cnt, 0);
        check("t6_errs", err_cnt, 0);
`endif
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        tick();

        do_start(17, 3);
        wait_idle(lat);
        exp_push(5, 2, 0);
        pop_check("post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
